// File: rtl/usb_cmd_pkg.sv
// Shared constants, state encoding and checksum helper
// for the USB host command parser and its response transmitter.
package usb_cmd_pkg;

  localparam logic [7:0] SYNC    = 8'hAA;
  localparam logic [7:0] CMD_WR  = 8'h01;
  localparam logic [7:0] CMD_RD  = 8'h02;
  localparam logic [7:0] RSP_ACK = 8'h55;
  localparam logic [7:0] RSP_RD  = 8'h5A;
  localparam logic [7:0] RSP_ERR = 8'hEE;

  typedef enum logic [2:0] {
    HUNT,
    RX,
    CHECK,
    EXEC_WR,
    EXEC_RD,
    RD_WAIT,
    TX
  } state_e;

  // body = {CMD, ADDR, DHI, DLO}
  function automatic logic [7:0] frame_chk(
    input logic [31:0] body
  );
    return body[31:24] ^ body[23:16] ^ body[15:8] ^ body[7:0];
  endfunction

endpackage

// File: rtl/usb_rsp_tx.sv
// Response transmitter: 4-byte buffer drained into the bridge write FIFO.
// Ports: load_i/len_i/data_i load a 2- or 4-byte response; wr_en_o/wr_data_o push; busy_o while draining.
module usb_rsp_tx (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [2:0]      len_i,
  input  logic [3:0][7:0] data_i,
  input  logic            wr_full_i,
  output logic            wr_en_o,
  output logic [7:0]      wr_data_o,
  output logic            busy_o
);

  logic [3:0][7:0] mem_q, mem_d;
  logic [2:0]      len_q, len_d;
  logic [1:0]      idx_q, idx_d;
  logic            busy_q, busy_d;
  logic            last;

  // A push happens exactly when wr_en_o is high, so the index
  // advances only on accepted bytes: nothing dropped or repeated.
  assign wr_en_o   = busy_q && !wr_full_i;
  assign wr_data_o = mem_q[idx_q];
  assign busy_o    = busy_q;
  assign last      = ({1'b0, idx_q} == (len_q - 3'd1));

  always_comb begin
    mem_d  = mem_q;
    len_d  = len_q;
    idx_d  = idx_q;
    busy_d = busy_q;
    if (load_i) begin
      mem_d  = data_i;
      len_d  = len_i;
      idx_d  = 2'd0;
      busy_d = 1'b1;
    end else if (wr_en_o) begin
      if (last) begin
        idx_d  = 2'd0;
        busy_d = 1'b0;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q  <= '0;
      len_q  <= '0;
      idx_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      len_q  <= len_d;
      idx_q  <= idx_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/usb_cmd_parser.sv
// Host command parser: 6-byte frames from the bridge read FIFO become
// register strobes; responses go to the bridge write FIFO via usb_rsp_tx.
// Ports: rd_* read FIFO, wr_* write FIFO, reg_* register bus, err_count bad frames.
module usb_cmd_parser
  import usb_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC,
  parameter int         TIMEOUT   = 48000
) (
  input  logic        clk_48mhz,
  input  logic        resetn,
  output logic        rd_en,
  input  logic [7:0]  rd_data,
  input  logic        rd_empty,
  output logic        wr_en,
  output logic [7:0]  wr_data,
  input  logic        wr_full,
  output logic        reg_wr,
  output logic        reg_rd,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  input  logic [15:0] reg_rdata,
  output logic [7:0]  err_count
);

  localparam int CW = $clog2(TIMEOUT);

  state_e          state_q, state_d;
  logic            rd_en_q, rd_en_d;
  logic            vld_q;
  logic [2:0]      idx_q, idx_d;
  logic [39:0]     sh_q, sh_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      err_q, err_d;
  logic [7:0]      addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic            err_inc;
  logic            fetch;
  logic            tx_load;
  logic [2:0]      tx_len;
  logic [3:0][7:0] tx_data;
  logic            tx_busy;
  logic [7:0]      cmd;
  logic            frame_ok;

  assign rd_en     = rd_en_q;
  assign reg_wr    = (state_q == EXEC_WR);
  assign reg_rd    = (state_q == EXEC_RD);
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign err_count = err_q;

  // In CHECK: sh_q = {CMD, ADDR, DHI, DLO, CHK}
  assign cmd      = sh_q[39:32];
  assign frame_ok = (sh_q[7:0] == frame_chk(sh_q[39:8]))
                 && (cmd == CMD_WR || cmd == CMD_RD);
  assign fetch    = (state_q == HUNT) || (state_q == RX);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_inc = 1'b0;
    tx_load = 1'b0;
    tx_len  = 3'd2;
    tx_data = '0;
    // Only one byte in flight: a fetch is issued when no pop is
    // pending or landing, so a state exit never strands a byte.
    rd_en_d = fetch && !rd_en_q && !vld_q && !rd_empty;
    unique case (state_q)
      HUNT: begin
        if (vld_q && rd_data == SYNC_BYTE) begin
          state_d = RX;
          idx_d   = 3'd0;
          cnt_d   = '0;
        end
      end
      RX: begin
        if (vld_q) begin
          sh_d  = {sh_q[31:0], rd_data};
          cnt_d = '0;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd4) begin
            state_d = CHECK;
            addr_d  = sh_q[23:16];
            wdata_d = sh_q[15:0];
          end
        end else if (rd_en_q) begin
          cnt_d = '0;
        end else if (rd_empty) begin
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_d = HUNT;
            err_inc = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      CHECK: begin
        if (!frame_ok) begin
          err_inc    = 1'b1;
          tx_load    = 1'b1;
          tx_data[0] = RSP_ERR;
          tx_data[1] = cmd;
          state_d    = TX;
        end else if (cmd == CMD_WR) begin
          state_d = EXEC_WR;
        end else begin
          state_d = EXEC_RD;
        end
      end
      EXEC_WR: begin
        tx_load    = 1'b1;
        tx_data[0] = RSP_ACK;
        tx_data[1] = addr_q;
        state_d    = TX;
      end
      EXEC_RD: state_d = RD_WAIT;
      RD_WAIT: begin
        tx_load    = 1'b1;
        tx_len     = 3'd4;
        tx_data[0] = RSP_RD;
        tx_data[1] = addr_q;
        tx_data[2] = reg_rdata[15:8];
        tx_data[3] = reg_rdata[7:0];
        state_d    = TX;
      end
      TX: begin
        if (!tx_busy) state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase
    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk_48mhz or negedge resetn) begin
    if (!resetn) begin
      state_q <= HUNT;
      rd_en_q <= 1'b0;
      vld_q   <= 1'b0;
      idx_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rd_en_q <= rd_en_d;
      vld_q   <= rd_en_q;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  usb_rsp_tx u_tx (
    .clk_i     (clk_48mhz),
    .rst_ni    (resetn),
    .load_i    (tx_load),
    .len_i     (tx_len),
    .data_i    (tx_data),
    .wr_full_i (wr_full),
    .wr_en_o   (wr_en),
    .wr_data_o (wr_data),
    .busy_o    (tx_busy)
  );

endmodule

// File: tb/tb_usb_cmd_parser.sv
// Scoreboard bench for usb_cmd_parser: frame-level reference model
// pushes expected strobes/bytes; a negedge monitor pops and compares.
module tb_usb_cmd_parser;

  localparam int TO = 64;

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
  } reg_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rd_en;
  logic [7:0]  rd_data = 8'h00;
  logic        rd_empty = 1'b1;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        wr_full = 1'b0;
  logic        reg_wr;
  logic        reg_rd;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata = 16'h0;
  logic [7:0]  err_count;

  int          checks = 0;
  int          errors = 0;
  int          model_err = 0;
  int          max_gap = 2;
  int          full_pct = 25;
  logic        full_force = 1'b0;
  logic        rd_hold = 1'b0;
  logic [7:0]  prev_addr = 8'h0;
  logic [15:0] prev_wdata = 16'h0;

  logic [7:0]  hostq[$];
  logic [7:0]  exp_tx[$];
  reg_t        exp_reg[$];
  logic [15:0] rdq[$];

  always #5 clk = ~clk;

  usb_cmd_parser #(.TIMEOUT(TO)) dut (
    .clk_48mhz (clk),
    .resetn    (resetn),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_empty  (rd_empty),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_full   (wr_full),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .err_count (err_count)
  );

  // Bridge read FIFO: data appears the cycle after the pop.
  always @(posedge clk) begin
    if (rd_en && hostq.size() != 0) rd_data <= hostq.pop_front();
    rd_empty <= (hostq.size() == 0);
  end

  // Bridge write FIFO backpressure, changed away from the edges.
  initial forever begin
    @(posedge clk);
    #1;
    wr_full = full_force || ($urandom_range(0, 99) < full_pct);
  end

  // Monitor + register responder.
  always @(negedge clk) begin
    if (resetn) begin
      if (reg_wr && reg_rd) begin
        errors++;
        $display("FAIL strobe_overlap got wr=%0b rd=%0b need exclusive", reg_wr, reg_rd);
      end
      if (rd_en && rd_empty) begin
        errors++;
        $display("FAIL rd_en_empty got rd_en=1 with rd_empty=1 need 0");
      end
      if (wr_en) begin
        checks++;
        if (wr_full) begin
          errors++;
          $display("FAIL wr_en_full got wr_en=1 with wr_full=1 need 0");
        end else if (exp_tx.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected got byte %h need none", wr_data);
        end else begin
          logic [7:0] e;
          e = exp_tx.pop_front();
          if (wr_data !== e) begin
            errors++;
            $display("FAIL tx_byte got %h need %h", wr_data, e);
          end
        end
      end
      if (reg_wr || reg_rd) begin
        checks++;
        if (exp_reg.size() == 0) begin
          errors++;
          $display("FAIL strobe_unexpected got wr=%0b rd=%0b addr=%h need none", reg_wr, reg_rd, reg_addr);
        end else begin
          reg_t r;
          r = exp_reg.pop_front();
          if (reg_wr !== r.wr || reg_addr !== r.addr || (r.wr && reg_wdata !== r.wdata)) begin
            errors++;
            $display("FAIL strobe got wr=%0b addr=%h wdata=%h need wr=%0b addr=%h wdata=%h",
                     reg_wr, reg_addr, reg_wdata, r.wr, r.addr, r.wdata);
          end
          if (reg_addr !== prev_addr || reg_wdata !== prev_wdata) begin
            errors++;
            $display("FAIL setup got prev addr/wdata %h/%h need %h/%h",
                     prev_addr, prev_wdata, reg_addr, reg_wdata);
          end
        end
      end
    end
    // reg_rdata is only meaningful in the cycle after reg_rd.
    if (resetn && reg_rd) begin
      reg_rdata = (rdq.size() != 0) ? rdq.pop_front() : 16'hDEAD;
      rd_hold   = 1'b1;
    end else if (rd_hold) begin
      rd_hold = 1'b0;
    end else begin
      reg_rdata = 16'($urandom);
    end
    prev_addr  = reg_addr;
    prev_wdata = reg_wdata;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    hostq.push_back(b);
    repeat ($urandom_range(0, max_gap)) @(negedge clk);
  endtask

  // Reference model: frame in -> strobes, response bytes, error count.
  task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                            input logic [15:0] d, input logic [7:0] chk);
    logic [15:0] rv;
    if (chk != (c ^ a ^ d[15:8] ^ d[7:0]) || (c != 8'h01 && c != 8'h02)) begin
      if (model_err < 255) model_err++;
      exp_tx.push_back(8'hEE);
      exp_tx.push_back(c);
    end else if (c == 8'h01) begin
      exp_reg.push_back('{wr: 1'b1, addr: a, wdata: d});
      exp_tx.push_back(8'h55);
      exp_tx.push_back(a);
    end else begin
      rv = 16'($urandom);
      if (a == 8'h20) rv = 16'hBEEF;
      rdq.push_back(rv);
      exp_reg.push_back('{wr: 1'b0, addr: a, wdata: 16'h0});
      exp_tx.push_back(8'h5A);
      exp_tx.push_back(a);
      exp_tx.push_back(rv[15:8]);
      exp_tx.push_back(rv[7:0]);
    end
    send_byte(8'hAA);
    send_byte(c);
    send_byte(a);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
    send_byte(chk);
  endtask

  task automatic good(input logic [7:0] c, input logic [7:0] a, input logic [15:0] d);
    send_frame(c, a, d, c ^ a ^ d[15:8] ^ d[7:0]);
  endtask

  task automatic chk_err(input string tag);
    checks++;
    if (err_count !== 8'(model_err)) begin
      errors++;
      $display("FAIL err_count_%s got %0d need %0d", tag, err_count, model_err);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((hostq.size() != 0 || exp_tx.size() != 0 || exp_reg.size() != 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20000) begin
      errors++;
      $display("FAIL drain_%s got %0d bytes/%0d strobes pending need 0", tag, exp_tx.size(), exp_reg.size());
      exp_tx.delete();
      exp_reg.delete();
    end
    repeat (10) @(negedge clk);
    chk_err(tag);
  endtask

  task automatic chk_reset(input string tag);
    logic [43:0] v;
    #1;
    v = {rd_en, wr_en, reg_wr, reg_rd, wr_data, reg_addr, reg_wdata, err_count};
    checks++;
    if (v !== 44'h0) begin
      errors++;
      $display("FAIL reset_%s got %h need 0", tag, v);
    end
  endtask

  initial begin
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("init");
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // Directed frames
    good(8'h01, 8'h10, 16'h1234);
    drain("write");
    good(8'h02, 8'h20, 16'h0000);
    drain("read");
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h13);
    good(8'h01, 8'h10, 16'h1234);
    drain("garbage");
    send_frame(8'h01, 8'h10, 16'h1234, 8'h00);
    drain("badchk");
    good(8'h07, 8'h10, 16'h1234);
    drain("badcmd");
    good(8'h01, 8'hAA, 16'hAAAA);
    drain("sync_as_data");

    // Backpressure held across a read response
    begin
      int n = 0;
      full_force = 1'b1;
      good(8'h02, 8'h33, 16'h0000);
      while (exp_reg.size() != 0 && n < 500) begin
        @(negedge clk);
        n++;
      end
      repeat (20) @(negedge clk);
      checks++;
      if (exp_tx.size() != 4) begin
        errors++;
        $display("FAIL full_hold got %0d bytes pending need 4", exp_tx.size());
      end
      full_force = 1'b0;
      drain("full_hold");
    end

    // Gap just below the timeout: frame still accepted
    send_byte(8'hAA);
    send_byte(8'h01);
    repeat (TO - 10) @(negedge clk);
    exp_reg.push_back('{wr: 1'b1, addr: 8'h44, wdata: 16'h5566});
    exp_tx.push_back(8'h55);
    exp_tx.push_back(8'h44);
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h66);
    send_byte(8'h01 ^ 8'h44 ^ 8'h55 ^ 8'h66);
    drain("near_timeout");

    // Timeout mid-frame: no response, error counted, then resync
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h10);
    repeat (TO + 20) @(negedge clk);
    model_err++;
    chk_err("timeout");
    good(8'h01, 8'h10, 16'h1234);
    drain("after_timeout");

    // Randomized frames
    for (int i = 0; i < 60; i++) begin
      int          kind;
      logic [7:0]  c, a, g;
      logic [15:0] d;
      kind = $urandom_range(0, 3);
      a    = 8'($urandom);
      d    = 16'($urandom);
      repeat ($urandom_range(0, 2)) begin
        g = 8'($urandom);
        if (g == 8'hAA) g = 8'h00;
        send_byte(g);
      end
      case (kind)
        0: good(8'h01, a, d);
        1: good(8'h02, a, d);
        2: begin
          c = 8'($urandom_range(1, 2));
          send_frame(c, a, d, (c ^ a ^ d[15:8] ^ d[7:0]) ^ 8'($urandom_range(1, 255)));
        end
        default: begin
          c = 8'($urandom_range(3, 255));
          good(c, a, d);
        end
      endcase
    end
    drain("random");

    // Saturation of the error counter
    max_gap = 0;
    for (int i = 0; i < 250; i++) good(8'h09, 8'(i), 16'h0);
    drain("saturate");
    max_gap = 2;

    // Reset in the middle of a stalled response
    full_force = 1'b1;
    good(8'h02, 8'h77, 16'h0);
    repeat (40) @(negedge clk);
    #2;
    resetn = 1'b0;
    exp_tx.delete();
    exp_reg.delete();
    rdq.delete();
    model_err = 0;
    chk_reset("mid_tx");
    @(negedge clk);
    resetn = 1'b1;
    full_force = 1'b0;
    repeat (30) @(negedge clk);
    good(8'h01, 8'h5C, 16'hC0DE);
    drain("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
